// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential NxN matrix multiplier: FSM state encoding
// and the signed saturating width conversion used when MATMUL_SAT_EN is defined.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        DONE
    } state_t;

    // Wide enough to carry any accumulator this block can be configured for.
    localparam int unsigned CONV_W = 64;

    function automatic logic signed [CONV_W-1:0] sat_conv(
        input logic signed [CONV_W-1:0] v,
        input int unsigned              out_w
    );
        logic signed [CONV_W-1:0] hi;
        logic signed [CONV_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/matmul_nxn_seq_lane.sv
// One signed DW x DW multiply-accumulate lane; sum presents acc + a*b combinationally
// so the row-final value can be stored in the same cycle the accumulator clears.
module matmul_lane #(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] acc;
    logic [2*DW-1:0]  prod;

    // Sign-extended operands: the low 2*DW bits of the product are the signed product.
    assign prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    assign sum  = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_nxn_seq.sv
// Sequential NxN signed matrix multiplier with N parallel MAC lanes (one per C column).
// Define MATMUL_SAT_EN for clamping result conversion with sticky ovf; default wraps.
module matmul_nxn_seq
    import matmul_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [2*$clog2(N)-1:0] wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  start,
    input  logic [2*$clog2(N)-1:0] rd_addr,
    output logic [OUT_W-1:0]      rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned ACC_W = 2 * DW + AW;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t state_q, state_d;

    logic [AW-1:0]    i_q, k_q;
    logic [DW-1:0]    a_mem [N][N];
    logic [DW-1:0]    b_mem [N][N];
    logic [OUT_W-1:0] c_mem [N][N];

    logic [ACC_W-1:0] lane_sum [N];
    logic [OUT_W-1:0] c_next   [N];

    logic compute, row_end, lane_clr;
    logic [AW-1:0] wr_row, wr_col, rd_row, rd_col;

    assign wr_row = wr_addr[2*AW-1:AW];
    assign wr_col = wr_addr[AW-1:0];
    assign rd_row = rd_addr[2*AW-1:AW];
    assign rd_col = rd_addr[AW-1:0];

    assign compute  = (state_q == COMPUTE);
    assign row_end  = compute && (k_q == LAST);
    assign lane_clr = (state_q == CLEAR) || row_end;
    assign busy     = (state_q == CLEAR) || compute;
    assign done     = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = COMPUTE;
            COMPUTE: if ((i_q == LAST) && (k_q == LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_q <= '0;
            k_q <= '0;
        end else if (state_q == CLEAR) begin
            i_q <= '0;
            k_q <= '0;
        end else if (compute) begin
            k_q <= k_q + 1'b1;
            if (k_q == LAST) begin
                i_q <= i_q + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        matmul_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (compute),
            .a   (a_mem[i_q][k_q]),
            .b   (b_mem[k_q][j]),
            .sum (lane_sum[j])
        );
    end

`ifdef MATMUL_SAT_EN
    logic [N-1:0]             clamp;
    logic signed [CONV_W-1:0] ext [N];
    logic signed [CONV_W-1:0] cv  [N];

    always_comb begin
        clamp = '0;
        for (int unsigned j = 0; j < N; j++) begin
            ext[j]    = CONV_W'($signed(lane_sum[j]));
            cv[j]     = sat_conv(ext[j], OUT_W);
            c_next[j] = cv[j][OUT_W-1:0];
            clamp[j]  = (cv[j] != ext[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (state_q == CLEAR) begin
            ovf <= 1'b0;
        end else if (row_end && (|clamp)) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_sum;

    always_comb begin
        unused_sum = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            c_next[j]  = lane_sum[j][OUT_W-1:0];
            unused_sum = unused_sum ^ (^lane_sum[j]);
        end
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                    c_mem[r][c] <= '0;
                end
            end
        end else begin
            if ((state_q == IDLE) && wr_en) begin
                if (wr_sel) begin
                    b_mem[wr_row][wr_col] <= wr_data;
                end else begin
                    a_mem[wr_row][wr_col] <= wr_data;
                end
            end
            if (row_end) begin
                for (int unsigned j = 0; j < N; j++) begin
                    c_mem[i_q][j] <= c_next[j];
                end
            end
        end
    end

    // Keyed on the next state so the port is already zero in the first busy cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if ((state_d == IDLE) || (state_d == DONE)) begin
            rd_data <= c_mem[rd_row][rd_col];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_matmul_nxn_seq.sv
// Scoreboard bench for matmul_nxn_seq (N=8, DW=8, OUT_W=16); expectations follow MATMUL_SAT_EN.
module tb_matmul_nxn_seq;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int OUT_W = 16;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              wr_en   = 1'b0;
    logic              wr_sel  = 1'b0;
    logic [5:0]        wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              start   = 1'b0;
    logic [5:0]        rd_addr = '0;
    logic [OUT_W-1:0]  rd_data;
    logic              busy, done, ovf;

    always #5 clk = ~clk;

    matmul_nxn_seq #(
        .N     (N),
        .DW    (DW),
        .OUT_W (OUT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string nm;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   ma [8][8];
    int   mb [8][8];
    int   mc [8][8];

    logic rd_req   = 1'b0;
    logic rd_req_q = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_req_q <= rd_req;

    // Monitor: a read request issued last cycle has its data on rd_data now.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_req_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk(e.nm, int'($signed(rd_data)), e.exp);
            end
        end
    end

    task automatic write_el(input bit sel, input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 6'(r * 8 + c);
        wr_data = DW'(d);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic load_all(input bit skip_last_b);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                write_el(1'b0, r, c, ma[r][c]);
                if (!(skip_last_b && r == N - 1 && c == N - 1)) begin
                    write_el(1'b1, r, c, mb[r][c]);
                end
            end
        end
    endtask

    task automatic read_all(input string nm);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                rd_addr = 6'(r * 8 + c);
                rd_req  = 1'b1;
                sb.push_back('{$sformatf("%s_c[%0d][%0d]", nm, r, c), mc[r][c]});
                @(posedge clk); #1;
            end
        end
        rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input bit disturb, input int exp_ovf);
        int lat, bcnt;
        bit got;
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        start = 1'b1;
        while (!got && lat < 200) begin
            @(posedge clk); #1;
            start = 1'b0;
            wr_en = 1'b0;
            lat++;
            if (disturb && lat == 10) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 6'd63;
                wr_data = 8'd5;
                rd_addr = 6'd9;
                rd_req  = 1'b1;
                sb.push_back('{$sformatf("%s_rd_busy", nm), 0});
            end
            if (disturb && lat == 11) rd_req = 1'b0;
            @(negedge clk);
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        chk($sformatf("%s_latency", nm), lat, N * N + 2);
        chk($sformatf("%s_busy_cycles", nm), bcnt, N * N + 1);
        chk($sformatf("%s_ovf", nm), int'(ovf), exp_ovf);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("%s_done_single", nm), int'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic set_identity_b();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = 8 * r + c;
                mc[r][c] = 8 * r + c;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",    int'(busy), 0);
        chk("reset_done",    int'(done), 0);
        chk("reset_ovf",     int'(ovf), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Identity; last B element written in the same cycle as start.
        set_identity_b();
        load_all(1'b1);
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd63; wr_data = 8'd63;
        run("ident", 1'b0, 0);
        read_all("ident");

        // All 127 x 127: row sum 129032.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 127;
                mb[r][c] = 127;
`ifdef MATMUL_SAT_EN
                mc[r][c] = 32767;
`else
                mc[r][c] = -2040;
`endif
            end
        end
        load_all(1'b0);
`ifdef MATMUL_SAT_EN
        run("satpos", 1'b0, 1);
`else
        run("satpos", 1'b0, 0);
`endif
        read_all("satpos");

        // All -128 x 127: row sum -130048.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = -128;
`ifdef MATMUL_SAT_EN
                mc[r][c] = -32768;
`else
                mc[r][c] = 1024;
`endif
            end
        end
        load_all(1'b0);
`ifdef MATMUL_SAT_EN
        run("satneg", 1'b0, 1);
`else
        run("satneg", 1'b0, 0);
`endif
        read_all("satneg");

        // start/wr_en/read while busy must not disturb the result.
        set_identity_b();
        load_all(1'b0);
        run("proto", 1'b1, 0);
        read_all("proto");

        // Reset in the middle of COMPUTE.
        start = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",    int'(busy), 0);
        chk("midrst_done",    int'(done), 0);
        chk("midrst_ovf",     int'(ovf), 0);
        chk("midrst_rd_data", int'(rd_data), 0);
        @(posedge clk); #1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mc[r][c] = 0;
        read_all("midrst");

        // Fresh load after reset: A = 2I, B[r][c] = r - c, so C = 2(r - c).
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 2 : 0;
                mb[r][c] = r - c;
                mc[r][c] = 2 * (r - c);
            end
        end
        load_all(1'b0);
        run("fresh", 1'b0, 0);
        read_all("fresh");

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
